// File: rtl/thermostat_ctrl.sv
// Hysteresis fan controller: IDLE -> RUN_MIN (on-dwell) -> RUN -> COOLDOWN (off-lockout) -> IDLE.
// Latency 1 cycle from the sampling edge to fanOn/fanState; no backpressure, samples gated by sampleValid.
// Optional over-temperature alarm (overTemp) is built only when THERMO_ALARM_EN is defined.
module thermostat_ctrl #(
    parameter int TEMP_W      = 8,
    parameter int HYST        = 2,
    parameter int MIN_ON_CYC  = 4,
    parameter int MIN_OFF_CYC = 3,
    parameter int ALARM_DELTA = 10,
    parameter int ALARM_CNT   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TEMP_W-1:0] presetTemp,
    input  logic [TEMP_W-1:0] currentTemp,
    input  logic              sampleValid,
    output logic              fanOn,
    output logic [1:0]        fanState
`ifdef THERMO_ALARM_EN
    ,
    output logic              overTemp
`endif
);

    localparam int DWELL_MAX = (MIN_ON_CYC > MIN_OFF_CYC) ? MIN_ON_CYC : MIN_OFF_CYC;
    localparam int CW        = $clog2(DWELL_MAX) + 1;
    localparam int XW        = TEMP_W + 1;

    localparam logic [CW-1:0] ON_LOAD  = CW'(MIN_ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(MIN_OFF_CYC - 1);
    localparam logic [XW-1:0] HYST_X   = XW'(HYST);

    if (TEMP_W < 3 || MIN_ON_CYC < 1 || MIN_OFF_CYC < 1 || ALARM_CNT < 1 || ALARM_DELTA < 0)
    begin : g_bad_params
        $error("thermostat_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN_MIN  = 2'b01,
        RUN      = 2'b10,
        COOLDOWN = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] dwell_cnt;
    logic [CW-1:0] dwell_nxt;

    logic [XW-1:0] cur_x;
    logic [XW-1:0] pre_x;
    logic [XW-1:0] hot_thr;
    logic [XW-1:0] cool_thr;
    logic          hot;
    logic          cool;

    // One extra bit keeps setpoint+HYST from wrapping; the cool bound clamps at zero.
    assign cur_x    = {1'b0, currentTemp};
    assign pre_x    = {1'b0, presetTemp};
    assign hot_thr  = pre_x + HYST_X;
    assign cool_thr = (pre_x >= HYST_X) ? (pre_x - HYST_X) : '0;
    assign hot      = (cur_x > hot_thr);
    assign cool     = (cur_x <= cool_thr);

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        case (state)
            IDLE: begin
                if (sampleValid && hot) begin
                    state_nxt = RUN_MIN;
                    dwell_nxt = ON_LOAD;
                end
            end
            RUN_MIN: begin
                if (dwell_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    dwell_nxt = dwell_cnt - CW'(1);
                end
            end
            RUN: begin
                if (sampleValid && cool) begin
                    state_nxt = COOLDOWN;
                    dwell_nxt = OFF_LOAD;
                end
            end
            COOLDOWN: begin
                if (dwell_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    dwell_nxt = dwell_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                dwell_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            fanOn     <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_nxt;
            fanOn     <= (state_nxt == RUN_MIN) || (state_nxt == RUN);
        end
    end

    assign fanState = state;

`ifdef THERMO_ALARM_EN
    localparam int            AW        = $clog2(ALARM_CNT + 1);
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_CNT);
    localparam logic [XW-1:0] DELTA_X   = XW'(ALARM_DELTA);

    logic [AW-1:0] alarm_cnt;
    logic [AW-1:0] alarm_nxt;
    logic          over_thr;

    assign over_thr = (cur_x > (pre_x + DELTA_X));

    // Runs beside the FSM and never feeds it; overTemp tracks the saturated count.
    always_comb begin
        alarm_nxt = alarm_cnt;
        if (sampleValid) begin
            if (!over_thr) begin
                alarm_nxt = '0;
            end else if (alarm_cnt != ALARM_MAX) begin
                alarm_nxt = alarm_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_cnt <= '0;
            overTemp  <= 1'b0;
        end else begin
            alarm_cnt <= alarm_nxt;
            overTemp  <= (alarm_nxt == ALARM_MAX);
        end
    end
`endif

endmodule
